// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: operation codes and iterative-unit state codes shared by the
// EX-stage ALU and its multiply/divide unit.
// Optional feature macro: ALU_MDU_MULDIV_EN (iterative multiply/divide, HI/LO).
package alu_mdu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,
    OP_SLTU  = 5'd9,
    OP_SLL   = 5'd10,
    OP_SRL   = 5'd11,
    OP_SRA   = 5'd12,
    OP_MULT  = 5'd13,
    OP_MULTU = 5'd14,
    OP_DIV   = 5'd15,
    OP_DIVU  = 5'd16,
    OP_MFHI  = 5'd17,
    OP_MFLO  = 5'd18
  } op_e;

  // Iterative unit states; kept as plain constants for older tool flows.
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_RUN  = 2'd1;
  localparam mdu_state_t ST_DONE = 2'd2;

  // True for the ops that go through the multi-cycle unit.
  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: iterative multiply (shift-add) / divide (restoring) unit with
// its own HI/LO registers. One bit per cycle, BUS_WIDTH iterations.
// Only built when ALU_MDU_MULDIV_EN is defined.
`ifdef ALU_MDU_MULDIV_EN
import alu_mdu_pkg::*;

module alu_mdu_seq #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           op,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 fin,
  output logic [BUS_WIDTH-1:0] fin_lo,
  output logic [BUS_WIDTH-1:0] hi,
  output logic [BUS_WIDTH-1:0] lo
);
  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(BUS_WIDTH + 1);

  mdu_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          is_div_reg, neg_q_reg, neg_r_reg, div0_reg;
  logic [W-1:0]  m_reg, acc_reg, sh_reg, a_reg, hi_reg, lo_reg;

  // Operand decode at accept: signed ops work on magnitudes.
  logic         op_div, op_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & a[W-1];
  assign b_neg     = op_signed & b[W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  logic [W:0]     add_sum, div_trial;
  logic [W-1:0]   div_diff, acc_step, sh_step, hi_fin, lo_fin;
  logic           div_ge;
  logic [2*W-1:0] prod_step, prod_signed;

  // One iteration of the datapath plus sign fix-up for the final result.
  // acc holds product-high / partial remainder, sh holds multiplier / dividend-quotient.
  always_comb begin
    add_sum     = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, m_reg} : '0);
    div_trial   = {acc_reg, sh_reg[W-1]};
    div_ge      = (div_trial >= {1'b0, m_reg});
    // Only taken when trial >= divisor, so the difference fits in W bits.
    div_diff    = div_trial[W-1:0] - m_reg;
    if (is_div_reg) begin
      acc_step = div_ge ? div_diff : div_trial[W-1:0];
      sh_step  = {sh_reg[W-2:0], div_ge};
    end else begin
      acc_step = add_sum[W:1];
      sh_step  = {add_sum[0], sh_reg[W-1:1]};
    end
    prod_step   = {acc_step, sh_step};
    prod_signed = neg_q_reg ? -prod_step : prod_step;
    hi_fin      = prod_signed[2*W-1:W];
    lo_fin      = prod_signed[W-1:0];
    if (is_div_reg) begin
      if (div0_reg) begin
        hi_fin = a_reg;
        lo_fin = '1;
      end else begin
        // MIN / -1 falls out naturally: magnitude 2^(W-1) reads back as MIN, rem 0.
        lo_fin = neg_q_reg ? -sh_step : sh_step;
        hi_fin = neg_r_reg ? -acc_step : acc_step;
      end
    end
  end

  assign busy   = (state_reg == ST_RUN);
  assign fin    = (state_reg == ST_RUN) && (cnt_reg == CW'(1));
  assign fin_lo = lo_fin;
  assign hi     = hi_reg;
  assign lo     = lo_reg;

  // FSM, counter and iteration registers. DONE also accepts a new op so the
  // earliest restart is the edge right after the result cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      m_reg      <= '0;
      acc_reg    <= '0;
      sh_reg     <= '0;
      a_reg      <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          acc_reg <= acc_step;
          sh_reg  <= sh_step;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CW'(1)) begin
            hi_reg    <= hi_fin;
            lo_reg    <= lo_fin;
            state_reg <= ST_DONE;
          end
        end
        default: begin
          if (start) begin
            state_reg  <= ST_RUN;
            cnt_reg    <= CW'(W);
            is_div_reg <= op_div;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            div0_reg   <= op_div && (b == '0);
            m_reg      <= op_div ? b_mag : a_mag;
            sh_reg     <= op_div ? a_mag : b_mag;
            acc_reg    <= '0;
            a_reg      <= a;
          end else begin
            state_reg  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage integer ALU with registered result and flags, plus an
// optional iterative multiply/divide unit behind the in_valid/in_ready handshake.
// Optional feature macro: ALU_MDU_MULDIV_EN.
import alu_mdu_pkg::*;

module alu_mdu #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           op,
  input  logic [BUS_WIDTH-1:0] A,
  input  logic [BUS_WIDTH-1:0] B,
  output logic                 out_valid,
  output logic [BUS_WIDTH-1:0] C,
  output logic                 fg_zero,
  output logic                 fg_ovf,
  output logic                 busy
);
  localparam int W  = BUS_WIDTH;
  localparam int SW = $clog2(BUS_WIDTH);

  logic          accept, iter_op, mdu_busy, mdu_fin;
  logic [W-1:0]  fin_lo, sum_ab, dif_ab, res_next;
  logic          ovf_next;
  logic [SW-1:0] shamt;
  logic [W-1:0]  c_reg;
  logic          valid_reg, zero_reg, ovf_reg;

`ifdef ALU_MDU_MULDIV_EN
  logic [W-1:0] hi_val, lo_val;
  assign iter_op = is_iter_op(op);
  alu_mdu_seq #(.BUS_WIDTH(BUS_WIDTH)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_op),
    .op     (op),
    .a      (A),
    .b      (B),
    .busy   (mdu_busy),
    .fin    (mdu_fin),
    .fin_lo (fin_lo),
    .hi     (hi_val),
    .lo     (lo_val)
  );
`else
  assign iter_op  = 1'b0;
  assign mdu_busy = 1'b0;
  assign mdu_fin  = 1'b0;
  assign fin_lo   = '0;
`endif

  assign busy     = mdu_busy;
  assign in_ready = !mdu_busy;
  assign accept   = in_valid && in_ready;
  assign sum_ab   = A + B;
  assign dif_ab   = A - B;
  assign shamt    = B[SW-1:0];

  // Single-cycle result and overflow; unknown codes produce zero.
  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    case (op)
      OP_ADD: begin
        res_next = sum_ab;
        ovf_next = (A[W-1] == B[W-1]) && (sum_ab[W-1] != A[W-1]);
      end
      OP_ADDU: res_next = sum_ab;
      OP_SUB: begin
        res_next = dif_ab;
        ovf_next = (A[W-1] != B[W-1]) && (dif_ab[W-1] != A[W-1]);
      end
      OP_SUBU: res_next = dif_ab;
      OP_AND:  res_next = A & B;
      OP_OR:   res_next = A | B;
      OP_XOR:  res_next = A ^ B;
      OP_NOR:  res_next = ~(A | B);
      OP_SLT:  res_next = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res_next = {{(W-1){1'b0}}, (A < B)};
      OP_SLL:  res_next = A << shamt;
      OP_SRL:  res_next = A >> shamt;
      OP_SRA:  res_next = $unsigned($signed(A) >>> shamt);
`ifdef ALU_MDU_MULDIV_EN
      OP_MFHI: res_next = hi_val;
      OP_MFLO: res_next = lo_val;
`endif
      default: res_next = '0;
    endcase
  end

  // Result register: zero flag comes from the very value being written to C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg     <= '0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (accept && !iter_op) begin
      c_reg     <= res_next;
      zero_reg  <= (res_next == '0);
      ovf_reg   <= ovf_next;
      valid_reg <= 1'b1;
    end else if (mdu_fin) begin
      c_reg     <= fin_lo;
      zero_reg  <= (fin_lo == '0);
      ovf_reg   <= 1'b0;
      valid_reg <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign C         = c_reg;
  assign fg_zero   = zero_reg;
  assign fg_ovf    = ovf_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: table-driven and randomized checks of alu_mdu (BUS_WIDTH=32)
// against a plain-arithmetic reference model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op;
  logic [W-1:0]  A, B;
  logic          out_valid;
  logic [W-1:0]  C;
  logic          fg_zero, fg_ovf, busy;

  alu_mdu #(.BUS_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .C         (C),
    .fg_zero   (fg_zero),
    .fg_ovf    (fg_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  logic [31:0] obs_c, obs_hold;
  logic        obs_ovf, obs_zero, obs_busy, obs_ready, obs_pulse;
  int          obs_lat, obs_busy_cnt;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_iter(input logic [4:0] o);
`ifdef ALU_MDU_MULDIV_EN
    return (o >= 5'd13) && (o <= 5'd16);
`else
    return (o == 5'd0) && (o != 5'd0);
`endif
  endfunction

  // Reference model from the instruction-set definitions, 64-bit arithmetic.
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic ovf);
    longint sa, sb, r;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    c = '0;
    ovf = 1'b0;
    case (o)
      5'd0:  begin r = sa + sb; c = r[31:0]; ovf = (r > 64'sh7fffffff) || (r < -64'sh80000000); end
      5'd1:  c = a + b;
      5'd2:  begin r = sa - sb; c = r[31:0]; ovf = (r > 64'sh7fffffff) || (r < -64'sh80000000); end
      5'd3:  c = a - b;
      5'd4:  c = a & b;
      5'd5:  c = a | b;
      5'd6:  c = a ^ b;
      5'd7:  c = ~(a | b);
      5'd8:  c = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  c = (a < b) ? 32'd1 : 32'd0;
      5'd10: c = a << sh;
      5'd11: c = a >> sh;
      5'd12: begin r = sa >>> sh; c = r[31:0]; end
`ifdef ALU_MDU_MULDIV_EN
      5'd13: begin r = sa * sb; model_hi = r[63:32]; model_lo = r[31:0]; c = model_lo; end
      5'd14: begin p = {32'd0, a} * {32'd0, b}; model_hi = p[63:32]; model_lo = p[31:0]; c = model_lo; end
      5'd15: begin
        if (b == 0) begin model_hi = a; model_lo = '1; end
        else begin r = sa / sb; model_lo = r[31:0]; r = sa % sb; model_hi = r[31:0]; end
        c = model_lo;
      end
      5'd16: begin
        if (b == 0) begin model_hi = a; model_lo = '1; end
        else begin model_lo = a / b; model_hi = a % b; end
        c = model_lo;
      end
      5'd17: c = model_hi;
      5'd18: c = model_lo;
`endif
      default: c = '0;
    endcase
  endfunction

  // Drive one op for its accept edge, then follow it to the out_valid pulse.
  task automatic exec(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    obs_busy_cnt = 0;
    while (!out_valid && n < 40) begin
      if (busy) obs_busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    obs_lat   = out_valid ? n : -1;
    obs_c     = C;
    obs_ovf   = fg_ovf;
    obs_zero  = fg_zero;
    obs_busy  = busy;
    obs_ready = in_ready;
    @(posedge clk); #1;
    obs_pulse = out_valid;
    obs_hold  = C;
  endtask

  task automatic check_op(input string tag, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c_exp, input logic ovf_exp, input logic zero_exp);
    int lat_exp;
    lat_exp = is_iter(o) ? W : 0;
    chk({tag, " in_ready_before"}, in_ready, 1);
    exec(o, a, b);
    $display("txn %s op=%0d a=%h b=%h -> C=%h ovf=%0b zero=%0b lat=%0d", tag, o, a, b, obs_c, obs_ovf, obs_zero, obs_lat);
    chk({tag, " C"}, obs_c, c_exp);
    chk({tag, " fg_ovf"}, obs_ovf, ovf_exp);
    chk({tag, " fg_zero"}, obs_zero, zero_exp);
    chk({tag, " latency"}, obs_lat, lat_exp);
    chk({tag, " busy_cycles"}, obs_busy_cnt, lat_exp);
    chk({tag, " busy_at_result"}, obs_busy, 0);
    chk({tag, " ready_at_result"}, obs_ready, 1);
    chk({tag, " pulse_len"}, obs_pulse, 0);
    chk({tag, " C_hold"}, obs_hold, c_exp);
  endtask

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 7);
    case (s)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffffffff;
      3: return 32'h80000000;
      4: return 32'h7fffffff;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n, low, seen;
    logic [31:0] a, b, c;
    logic [4:0] o;
    logic ovf;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset C", C, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset fg_zero", fg_zero, 0);
    chk("reset fg_ovf", fg_ovf, 0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: op, A, B, expected C, ovf, zero.
    vecs.push_back('{OP_ADD,  32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1, 1'b0});
    vecs.push_back('{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_SRA,  32'h80000000, 32'h00000004, 32'hf8000000, 1'b0, 1'b0});
    vecs.push_back('{OP_ADDU, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_SUB,  32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, 1'b0});
    vecs.push_back('{OP_SUBU, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b0});
    vecs.push_back('{OP_ADD,  32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_AND,  32'hf0f0ff00, 32'h0ff0f0f0, 32'h00f0f000, 1'b0, 1'b0});
    vecs.push_back('{OP_OR,   32'hf0f0ff00, 32'h0ff0f0f0, 32'hfff0fff0, 1'b0, 1'b0});
    vecs.push_back('{OP_XOR,  32'hf0f0ff00, 32'h0ff0f0f0, 32'hff000ff0, 1'b0, 1'b0});
    vecs.push_back('{OP_NOR,  32'h00000000, 32'h00000000, 32'hffffffff, 1'b0, 1'b0});
    vecs.push_back('{OP_SLT,  32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{OP_SLTU, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0});
    vecs.push_back('{OP_SRL,  32'h80000000, 32'h0000001f, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{OP_SRA,  32'h7fffffff, 32'h0000001f, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{5'd19,   32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{5'd31,   32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b1});
`ifdef ALU_MDU_MULDIV_EN
    vecs.push_back('{OP_MULT,  32'hfffffffd, 32'h00000007, 32'hffffffeb, 1'b0, 1'b0});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'hffffffff, 1'b0, 1'b0});
    vecs.push_back('{OP_MFLO,  32'h0,        32'h0,        32'hffffffeb, 1'b0, 1'b0});
    vecs.push_back('{OP_DIV,   32'hfffffff9, 32'h00000002, 32'hfffffffd, 1'b0, 1'b0});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'hffffffff, 1'b0, 1'b0});
    vecs.push_back('{OP_DIVU,  32'h00000009, 32'h00000000, 32'hffffffff, 1'b0, 1'b0});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'h00000009, 1'b0, 1'b0});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hffffffff, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_MULTU, 32'hffffffff, 32'hffffffff, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'hfffffffe, 1'b0, 1'b0});
    vecs.push_back('{OP_DIV,   32'h00000007, 32'hfffffffe, 32'hfffffffd, 1'b0, 1'b0});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'h00000001, 1'b0, 1'b0});
`else
    vecs.push_back('{OP_MULT,  32'hfffffffd, 32'h00000007, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_DIVU,  32'h00000009, 32'h00000000, 32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_MFHI,  32'h0,        32'h0,        32'h00000000, 1'b0, 1'b1});
    vecs.push_back('{OP_MFLO,  32'h0,        32'h0,        32'h00000000, 1'b0, 1'b1});
`endif
    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].ovf, vecs[i].zero);

`ifdef ALU_MDU_MULDIV_EN
    // ADD held valid while a MULT runs: refused until the MULT result cycle.
    op = OP_MULT; A = 32'h12345678; B = 32'h00000100; in_valid = 1'b1;
    @(posedge clk); #1;
    op = OP_ADD; A = 32'd3; B = 32'd4;
    n = 0; low = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      n++;
    end
    $display("txn b2b mult C=%h after %0d cycles, ready low %0d", C, n, low);
    chk("b2b mult latency", n, W);
    chk("b2b ready_low_cycles", low, W);
    chk("b2b ready_at_result", in_ready, 1);
    chk("b2b mult C", C, 32'h34567800);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("txn b2b add C=%h", C);
    chk("b2b add out_valid", out_valid, 1);
    chk("b2b add C", C, 32'd7);
    @(posedge clk); #1;
    chk("b2b add pulse_len", out_valid, 0);

    // Reset at iteration 10 of a DIVU: result is dropped, HI/LO cleared.
    op = OP_DIVU; A = 32'd100; B = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst busy_async", busy, 0);
    chk("rst C_async", C, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst no_out_valid", seen, 0);
    model_hi = '0;
    model_lo = '0;
    check_op("rst mflo", OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_op("rst mfhi", OP_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
`endif

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      o = 5'($urandom_range(0, 21));
      a = pick();
      b = pick();
      model(o, a, b, c, ovf);
      check_op($sformatf("rnd%0d", i), o, a, b, c, ovf, (c == 32'h0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
